// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: operand forwarding, load-use/branch stall and flush,
// multi-cycle data-memory wait sequencing with timeout, and saturating perf counters.
module hazard_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic             MemReqM,
    input  logic             MemAckM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushEvents,
    output logic             mem_wait_dbg
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] TIMEOUT_V = WCW'(MEM_TIMEOUT);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_e;

    mem_state_e       state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             mem_stall, mem_timeout, lw_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Handshake: MemReqM is held by the Memory stage until the cycle MemAckM is high;
    // that ack cycle completes the access and is never itself a stall cycle.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        mem_stall   = 1'b0;
        mem_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemReqM && !MemAckM) begin
                    mem_stall  = 1'b1;
                    wait_cnt_d = WCW'(1);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (MemAckM) begin
                    state_d = IDLE;
                end else if (wait_cnt_q < TIMEOUT_V) begin
                    mem_stall  = 1'b1;
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end else begin
                    mem_timeout = 1'b1;
                    mem_err_d   = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ForwardAE  = 2'b00;
        ForwardBE  = 2'b00;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushW     = 1'b0;
        MemTimeout = 1'b0;
        lw_stall   = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
        if (!rst) begin
            if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)      ForwardAE = 2'b10;
            else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ForwardAE = 2'b01;
            if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)      ForwardBE = 2'b10;
            else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ForwardBE = 2'b01;
            MemTimeout = mem_timeout;
            // A frozen Execute stage makes load-use and redirect decisions moot until it moves.
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushD = PCSrcE;
                FlushE = lw_stall | PCSrcE;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (PCSrcE && !mem_stall && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    assign MemErr       = mem_err_q;
    assign StallCycles  = stall_cnt_q;
    assign FlushEvents  = flush_cnt_q;
    assign mem_wait_dbg = (state_q == WAIT);

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed test-plan scenarios followed by random traffic,
// all checked each cycle against a cycle-level behavioural model.
module tb_hazard_control_unit;

    localparam int T     = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic [1:0] ResultSrcE = '0;
    logic PCSrcE = 1'b0, RegWriteM = 1'b0, MemReqM = 1'b0, MemAckM = 1'b0, RegWriteW = 1'b0;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout, MemErr;
    logic [CNT_W-1:0] StallCycles, FlushEvents;
    logic mem_wait_dbg;

    int total = 0;
    int bad   = 0;

    // model state
    int m_waited = 0;   // stalled cycles of the outstanding request, 0 when none
    int m_err = 0, m_stalls = 0, m_flushes = 0;
    // observations captured at the last evaluated cycle
    logic [1:0] o_fa;
    logic [3:0] o_stall;
    logic [2:0] o_flush;
    logic o_to, o_err;
    int o_scnt, o_fcnt;

    hazard_control_unit #(.MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM),
        .MemReqM(MemReqM), .MemAckM(MemAckM), .RdW(RdW), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemTimeout(MemTimeout), .MemErr(MemErr),
        .StallCycles(StallCycles), .FlushEvents(FlushEvents), .mem_wait_dbg(mem_wait_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic step();
        bit mstall, tout, lw;
        logic [3:0] e_stall;
        logic [2:0] e_flush;
        @(negedge clk);
        mstall = (m_waited == 0) ? (MemReqM && !MemAckM) : (!MemAckM && m_waited < T);
        tout   = (m_waited != 0) && !MemAckM && (m_waited == T);
        lw     = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        if (rst) begin
            e_stall = 4'b0000;
            e_flush = 3'b000;
            tout    = 1'b0;
        end else if (mstall) begin
            e_stall = 4'b1111;
            e_flush = 3'b001;
        end else begin
            e_stall = {lw, lw, 2'b00};
            e_flush = {PCSrcE, lw | PCSrcE, 1'b0};
        end
        check_eq("fwd_a", ForwardAE, rst ? 2'b00 : fwd_sel(Rs1E));
        check_eq("fwd_b", ForwardBE, rst ? 2'b00 : fwd_sel(Rs2E));
        check_eq("stall_fdem", {StallF, StallD, StallE, StallM}, e_stall);
        check_eq("flush_dew", {FlushD, FlushE, FlushW}, e_flush);
        check_eq("mem_timeout", MemTimeout, tout);
        check_eq("mem_err", MemErr, m_err[0]);
        check_eq("stall_cycles", StallCycles, m_stalls);
        check_eq("flush_events", FlushEvents, m_flushes);
        check_eq("state_wait", mem_wait_dbg, m_waited != 0);
        o_fa = ForwardAE; o_stall = {StallF, StallD, StallE, StallM};
        o_flush = {FlushD, FlushE, FlushW}; o_to = MemTimeout; o_err = MemErr;
        o_scnt = int'(StallCycles); o_fcnt = int'(FlushEvents);
        @(posedge clk);
        if (rst) begin
            m_waited = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (e_stall[3]) m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
            if (PCSrcE && !mstall) m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
            if (m_waited == 0) begin
                if (MemReqM && !MemAckM) m_waited = 1;
            end else if (MemAckM) begin
                m_waited = 0;
            end else if (m_waited == T) begin
                m_waited = 0;
                m_err = 1;
            end else begin
                m_waited++;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        ResultSrcE = 2'b00;
        {PCSrcE, RegWriteM, MemReqM, MemAckM, RegWriteW} = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int s0;
        clear_inputs();
        @(posedge clk); #1;
        step();
        rst = 1'b0;
        step();
        check_eq("tp_reset_cnt", o_scnt, 0);

        // forwarding priority
        Rs1E = 5; RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1;
        step(); check_eq("tp_fwd_mem", o_fa, 2'b10);
        RegWriteM = 0;
        step(); check_eq("tp_fwd_wb", o_fa, 2'b01);
        RdM = 0; RdW = 0; RegWriteM = 1;
        step(); check_eq("tp_fwd_x0", o_fa, 2'b00);

        // load-use, then with RdE=0
        do_reset();
        ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
        step(); check_eq("tp_lw_stall", o_stall, 4'b1100); check_eq("tp_lw_flush", o_flush, 3'b010);
        RdE = 0;
        step(); check_eq("tp_lw_x0", o_stall, 4'b0000); check_eq("tp_lw_cnt", o_scnt, 1);

        // branch
        clear_inputs(); PCSrcE = 1;
        step(); check_eq("tp_br_flush", o_flush, 3'b110);
        PCSrcE = 0;
        step(); check_eq("tp_br_cnt", o_fcnt, 1);

        // memory wait of 3 cycles then ack
        do_reset();
        MemReqM = 1;
        for (int i = 0; i < 3; i++) begin
            step(); check_eq("tp_wait_stall", o_stall, 4'b1111);
        end
        MemAckM = 1;
        step(); check_eq("tp_ack_release", o_stall, 4'b0000);
        clear_inputs();
        step(); check_eq("tp_wait_cnt", o_scnt, 3);

        // timeout
        do_reset();
        MemReqM = 1;
        for (int i = 0; i < T; i++) begin
            step(); check_eq("tp_to_stall", o_stall, 4'b1111); check_eq("tp_to_nopulse", o_to, 1'b0);
        end
        step(); check_eq("tp_to_pulse", o_to, 1'b1); check_eq("tp_to_release", o_stall, 4'b0000);
        check_eq("tp_to_err_late", o_err, 1'b0);
        clear_inputs();
        step(); check_eq("tp_err_set", o_err, 1'b1); check_eq("tp_to_once", o_to, 1'b0);
        step(); check_eq("tp_err_sticky", o_err, 1'b1);

        // branch during memory stall, then reset in WAIT
        do_reset();
        MemReqM = 1;
        step();
        s0 = o_fcnt;
        PCSrcE = 1;
        step(); check_eq("tp_br_in_stall", o_flush, 3'b001);
        step(); check_eq("tp_br_in_stall_cnt", o_fcnt, s0);
        rst = 1;
        step(); check_eq("tp_rst_outs", {o_stall, o_flush, o_to}, 8'h00);
        rst = 0; clear_inputs();
        step(); check_eq("tp_rst_idle", o_stall, 4'b0000); check_eq("tp_rst_cnt", o_scnt, 0);

        // random traffic; small register range to make hazards frequent
        for (int n = 0; n < 2000; n++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            PCSrcE  = ($urandom_range(0, 3) == 0);
            MemReqM = ($urandom_range(0, 2) == 0);
            MemAckM = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
